rr_bus_arbiter: RTL and testbench

RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

---
 rtl/rr_bus_arbiter_if.sv | 27 ++
 rtl/rr_bus_arbiter.sv | 113 +++++++++++
 tb/tb_rr_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_bus_arbiter_if.sv
// Bus bundle between four requesters and the round-robin arbiter.
// The slave modport is the arbiter's view; master is the requesters' view.
interface rr_bus_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3:0]            REQ;
  logic [3:0]            DONE;
  logic [DATA_WIDTH-1:0] D0;
  logic [DATA_WIDTH-1:0] D1;
  logic [DATA_WIDTH-1:0] D2;
  logic [DATA_WIDTH-1:0] D3;
  logic [3:0]            GNT;
  logic [1:0]            GNT_ID;
  logic                  BUS_VALID;
  logic [DATA_WIDTH-1:0] Y;
  logic                  TIMEOUT_ERR;

  modport slave (
    input  REQ, DONE, D0, D1, D2, D3,
    output GNT, GNT_ID, BUS_VALID, Y, TIMEOUT_ERR
  );

  modport master (
    output REQ, DONE, D0, D1, D2, D3,
    input  GNT, GNT_ID, BUS_VALID, Y, TIMEOUT_ERR
  );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Four-way round-robin bus arbiter with a one-cycle turnaround gap between
// owners and forced revocation after TIMEOUT cycles of continuous ownership.
module rr_bus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input logic            CLK,
  input logic            RST,
  rr_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [3:0] HCNT_LAST = 4'(TIMEOUT - 1);

  state_e                state_q;
  logic [1:0]            ptr_q;
  logic [3:0]            hcnt_q;
  logic [3:0]            gnt_q;
  logic [1:0]            gntId_q;
  logic                  timeoutErr_q;

  logic [1:0]            winner_d;
  logic [1:0]            scanIdx;
  logic                  ownerRelease;
  logic                  ownerTimeout;
  logic [DATA_WIDTH-1:0] yMux;

  // Scan downward so the requester closest to PTR is the last one written.
  always_comb begin
    winner_d = ptr_q;
    scanIdx  = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      scanIdx = ptr_q + 2'(k);
      if (bus.REQ[scanIdx]) begin
        winner_d = scanIdx;
      end
    end
  end

  assign ownerRelease = bus.DONE[gntId_q] | ~bus.REQ[gntId_q];
  assign ownerTimeout = (hcnt_q == HCNT_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd0;
      hcnt_q       <= 4'd0;
      gnt_q        <= 4'b0000;
      gntId_q      <= 2'd0;
      timeoutErr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, GAP: begin
          timeoutErr_q <= 1'b0;
          if (|bus.REQ) begin
            state_q <= BUSY;
            gnt_q   <= 4'b0001 << winner_d;
            gntId_q <= winner_d;
            ptr_q   <= winner_d + 2'd1;
            hcnt_q  <= 4'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          // A voluntary release takes priority over a coincident timeout.
          if (ownerRelease) begin
            state_q <= GAP;
            gnt_q   <= 4'b0000;
            gntId_q <= 2'd0;
          end else if (ownerTimeout) begin
            state_q      <= GAP;
            gnt_q        <= 4'b0000;
            gntId_q      <= 2'd0;
            timeoutErr_q <= 1'b1;
          end else begin
            hcnt_q <= hcnt_q + 4'd1;
          end
        end
        default: begin
          state_q      <= IDLE;
          gnt_q        <= 4'b0000;
          gntId_q      <= 2'd0;
          timeoutErr_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    yMux = '0;
    if (state_q == BUSY) begin
      case (gntId_q)
        2'd0:    yMux = bus.D0;
        2'd1:    yMux = bus.D1;
        2'd2:    yMux = bus.D2;
        default: yMux = bus.D3;
      endcase
    end
  end

  assign bus.GNT         = gnt_q;
  assign bus.GNT_ID      = gntId_q;
  assign bus.BUS_VALID   = (state_q == BUSY);
  assign bus.Y           = yMux;
  assign bus.TIMEOUT_ERR = timeoutErr_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: directed scenarios plus a random
// run compared against an owner/pointer reference model.
module tb_rr_bus_arbiter;
  localparam int DW = 32;
  localparam int TO = 4;

  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  // Reference model: owner index (-1 when nobody owns), next scan start,
  // cycles held so far by the owner, and the pending timeout pulse.
  int   mOwner;
  int   mPtr;
  int   mHeld;
  bit   mErr;

  rr_bus_arbiter_if #(.DATA_WIDTH(DW)) bus();

  rr_bus_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    mOwner = -1;
    mPtr   = 0;
    mHeld  = 0;
    mErr   = 1'b0;
  endtask

  task automatic modelStep();
    logic [3:0] r;
    logic [3:0] d;
    bit         found;
    r     = bus.REQ;
    d     = bus.DONE;
    mErr  = 1'b0;
    found = 1'b0;
    if (mOwner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (!found && r[(mPtr + k) % 4]) begin
          mOwner = (mPtr + k) % 4;
          found  = 1'b1;
        end
      end
      if (found) begin
        mPtr  = (mOwner + 1) % 4;
        mHeld = 1;
      end
    end else if (d[mOwner] || !r[mOwner]) begin
      mOwner = -1;
    end else if (mHeld == TO) begin
      mOwner = -1;
      mErr   = 1'b1;
    end else begin
      mHeld++;
    end
  endtask

  function automatic logic [DW-1:0] dataOf(int i);
    case (i)
      0:       return bus.D0;
      1:       return bus.D1;
      2:       return bus.D2;
      default: return bus.D3;
    endcase
  endfunction

  task automatic stepClock();
    @(posedge CLK);
    modelStep();
    #1;
  endtask

  task automatic driveIdle();
    bus.REQ  = 4'b0000;
    bus.DONE = 4'b0000;
    bus.D0   = 32'h0000_0A0A;
    bus.D1   = 32'h0000_1B1B;
    bus.D2   = 32'h0000_2C2C;
    bus.D3   = 32'h0000_3D3D;
  endtask

  task automatic doReset();
    driveIdle();
    RST = 1'b1;
    modelReset();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    driveIdle();
    bus.REQ = 4'b1111;
    RST = 1'b1;
    modelReset();
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (bus.GNT !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 0000", bus.GNT); end
    checks++; if (bus.GNT_ID !== 2'd0) begin errors++; $display("[TB] FAIL reset_gnt_id: got %0d expected 0", bus.GNT_ID); end
    checks++; if (bus.BUS_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.BUS_VALID); end
    checks++; if (bus.TIMEOUT_ERR !== 1'b0) begin errors++; $display("[TB] FAIL reset_terr: got %b expected 0", bus.TIMEOUT_ERR); end
    checks++; if (bus.Y !== 32'd0) begin errors++; $display("[TB] FAIL reset_y: got %0h expected 0", bus.Y); end
    @(negedge CLK);
    RST = 1'b0;
    stepClock();
    checks++; if (bus.GNT !== 4'b0001) begin errors++; $display("[TB] FAIL reset_first_grant: got %b expected 0001", bus.GNT); end
    checks++; if (bus.Y !== 32'h0000_0A0A) begin errors++; $display("[TB] FAIL reset_first_y: got %0h expected a0a", bus.Y); end
  endtask

  task automatic test_single();
    doReset();
    bus.D2  = 32'd45;
    bus.REQ = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      stepClock();
      checks++; if (bus.GNT !== 4'b0100) begin errors++; $display("[TB] FAIL single_gnt c%0d: got %b expected 0100", c, bus.GNT); end
      checks++; if (bus.GNT_ID !== 2'd2) begin errors++; $display("[TB] FAIL single_id c%0d: got %0d expected 2", c, bus.GNT_ID); end
      checks++; if (bus.Y !== 32'd45) begin errors++; $display("[TB] FAIL single_y c%0d: got %0d expected 45", c, bus.Y); end
    end
    bus.DONE = 4'b0100;
    bus.REQ  = 4'b0000;
    stepClock();
    bus.DONE = 4'b0000;
    checks++; if (bus.GNT !== 4'b0000) begin errors++; $display("[TB] FAIL single_gap_gnt: got %b expected 0000", bus.GNT); end
    checks++; if (bus.Y !== 32'd0) begin errors++; $display("[TB] FAIL single_gap_y: got %0d expected 0", bus.Y); end
    checks++; if (bus.TIMEOUT_ERR !== 1'b0) begin errors++; $display("[TB] FAIL single_gap_terr: got %b expected 0", bus.TIMEOUT_ERR); end
    stepClock();
    checks++; if (bus.BUS_VALID !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_valid: got %b expected 0", bus.BUS_VALID); end
  endtask

  task automatic test_round_robin();
    int id;
    doReset();
    bus.REQ = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      id = g % 4;
      stepClock();
      checks++; if (bus.GNT !== (4'b0001 << id)) begin errors++; $display("[TB] FAIL rr_grant g%0d: got %b expected owner %0d", g, bus.GNT, id); end
      checks++; if (bus.Y !== dataOf(id)) begin errors++; $display("[TB] FAIL rr_y g%0d: got %0h expected %0h", g, bus.Y, dataOf(id)); end
      bus.DONE = 4'b0001 << id;
      stepClock();
      bus.DONE = 4'b0000;
      checks++; if (bus.BUS_VALID !== 1'b0) begin errors++; $display("[TB] FAIL rr_gap g%0d: got valid %b expected 0", g, bus.BUS_VALID); end
    end
  endtask

  task automatic test_timeout();
    doReset();
    bus.REQ = 4'b0001;
    for (int c = 1; c <= TO; c++) begin
      stepClock();
      checks++; if (bus.GNT !== 4'b0001) begin errors++; $display("[TB] FAIL to_hold c%0d: got %b expected 0001", c, bus.GNT); end
      checks++; if (bus.TIMEOUT_ERR !== 1'b0) begin errors++; $display("[TB] FAIL to_early_err c%0d: got %b expected 0", c, bus.TIMEOUT_ERR); end
    end
    stepClock();
    checks++; if (bus.GNT !== 4'b0000) begin errors++; $display("[TB] FAIL to_gap_gnt: got %b expected 0000", bus.GNT); end
    checks++; if (bus.TIMEOUT_ERR !== 1'b1) begin errors++; $display("[TB] FAIL to_err_pulse: got %b expected 1", bus.TIMEOUT_ERR); end
    stepClock();
    checks++; if (bus.GNT !== 4'b0001) begin errors++; $display("[TB] FAIL to_regrant: got %b expected 0001", bus.GNT); end
    checks++; if (bus.TIMEOUT_ERR !== 1'b0) begin errors++; $display("[TB] FAIL to_err_single: got %b expected 0", bus.TIMEOUT_ERR); end
  endtask

  task automatic test_simultaneous();
    doReset();
    bus.REQ = 4'b0011;
    stepClock();
    bus.DONE = 4'b0010;
    stepClock();
    bus.DONE = 4'b0000;
    checks++; if (bus.GNT !== 4'b0001) begin errors++; $display("[TB] FAIL sim_nonowner_done: got %b expected 0001", bus.GNT); end
    repeat (2) stepClock();
    bus.DONE = 4'b0001;
    stepClock();
    bus.DONE = 4'b0000;
    checks++; if (bus.GNT !== 4'b0000) begin errors++; $display("[TB] FAIL sim_release_gnt: got %b expected 0000", bus.GNT); end
    checks++; if (bus.TIMEOUT_ERR !== 1'b0) begin errors++; $display("[TB] FAIL sim_release_terr: got %b expected 0", bus.TIMEOUT_ERR); end
    stepClock();
    checks++; if (bus.GNT !== 4'b0010) begin errors++; $display("[TB] FAIL sim_next_owner: got %b expected 0010", bus.GNT); end
  endtask

  task automatic test_reset_mid_busy();
    doReset();
    bus.D3  = 32'd69;
    bus.REQ = 4'b1000;
    stepClock();
    checks++; if (bus.Y !== 32'd69) begin errors++; $display("[TB] FAIL rst_pre_y: got %0d expected 69", bus.Y); end
    #2;
    RST = 1'b1;
    modelReset();
    #1;
    checks++; if (bus.GNT !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_gnt: got %b expected 0000", bus.GNT); end
    checks++; if (bus.Y !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_y: got %0d expected 0", bus.Y); end
    checks++; if (bus.BUS_VALID !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", bus.BUS_VALID); end
    checks++; if (bus.TIMEOUT_ERR !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_terr: got %b expected 0", bus.TIMEOUT_ERR); end
    #1;
    RST = 1'b0;
    bus.REQ = 4'b1010;
    stepClock();
    checks++; if (bus.GNT !== 4'b0010) begin errors++; $display("[TB] FAIL rst_after_grant: got %b expected 0010", bus.GNT); end
  endtask

  task automatic test_random();
    logic [3:0] sampledReq;
    logic [3:0] expGnt;
    int         waitCnt [4];
    int         holdObs;
    bit         prevValid;
    bit         newGrant;
    int         j;
    doReset();
    for (int i = 0; i < 4; i++) waitCnt[i] = 0;
    holdObs   = 0;
    prevValid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) bus.REQ[b] = ~bus.REQ[b];
        bus.DONE[b] = ($urandom_range(5) == 0);
      end
      bus.D0 = $urandom;
      bus.D1 = $urandom;
      bus.D2 = $urandom;
      bus.D3 = $urandom;
      sampledReq = bus.REQ;
      stepClock();
      expGnt = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
      checks++; if (bus.GNT !== expGnt) begin errors++; $display("[TB] FAIL rand_gnt cyc%0d: got %b expected %b", cyc, bus.GNT, expGnt); end
      checks++; if (bus.BUS_VALID !== (mOwner >= 0)) begin errors++; $display("[TB] FAIL rand_valid cyc%0d: got %b expected %b", cyc, bus.BUS_VALID, mOwner >= 0); end
      checks++; if (bus.TIMEOUT_ERR !== mErr) begin errors++; $display("[TB] FAIL rand_terr cyc%0d: got %b expected %b", cyc, bus.TIMEOUT_ERR, mErr); end
      checks++; if (bus.Y !== ((mOwner >= 0) ? dataOf(mOwner) : 32'd0)) begin errors++; $display("[TB] FAIL rand_y cyc%0d: got %0h owner %0d", cyc, bus.Y, mOwner); end
      if (mOwner >= 0) begin
        checks++; if (bus.GNT_ID !== 2'(mOwner)) begin errors++; $display("[TB] FAIL rand_id cyc%0d: got %0d expected %0d", cyc, bus.GNT_ID, mOwner); end
      end
      holdObs = (bus.BUS_VALID === 1'b1) ? holdObs + 1 : 0;
      if (bus.BUS_VALID === 1'b1) begin
        checks++; if (holdObs > TO) begin errors++; $display("[TB] FAIL rand_max_hold cyc%0d: got %0d cycles limit %0d", cyc, holdObs, TO); end
      end
      newGrant = (bus.BUS_VALID === 1'b1) && !prevValid;
      j = int'(bus.GNT_ID);
      for (int i = 0; i < 4; i++) begin
        if (newGrant && i == j) begin
          checks++; if (waitCnt[i] > 3) begin errors++; $display("[TB] FAIL rand_fair req%0d cyc%0d: waited %0d grants limit 3", i, cyc, waitCnt[i]); end
          waitCnt[i] = 0;
        end else if (!sampledReq[i]) begin
          waitCnt[i] = 0;
        end else if (newGrant) begin
          waitCnt[i]++;
        end
      end
      prevValid = (bus.BUS_VALID === 1'b1);
    end
  endtask

  initial begin
    RST = 1'b1;
    driveIdle();
    modelReset();
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
